// File: rtl/vga_pkg.sv
// Shared 640x480@60 VGA timing constants, counter sizing limits and the
// line/frame period helper used by every VGA block.
package vga_pkg;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FRONT  = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BACK   = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FRONT  = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BACK   = 33;

    localparam int VGA_CNT_W     = 10;
    localparam int VGA_MAX_TOTAL = 1 << VGA_CNT_W;
    localparam int VGA_MAX_PIPE  = 4;

    function automatic int vga_total(input int active, input int front,
                                     input int sync, input int back);
        return active + front + sync + back;
    endfunction

    localparam int VGA_H_TOTAL = vga_total(VGA_H_ACTIVE, VGA_H_FRONT, VGA_H_SYNC, VGA_H_BACK);
    localparam int VGA_V_TOTAL = vga_total(VGA_V_ACTIVE, VGA_V_FRONT, VGA_V_SYNC, VGA_V_BACK);

    // Each field is 1 while the raw condition holds; polarity is applied downstream.
    typedef struct packed {
        logic active;
        logic vsync;
        logic hsync;
    } vga_sync_t;

endpackage

// File: rtl/vga_sync_delay.sv
// Resettable DEPTH-stage shift register that lines the sync/active flags up
// with a colour path of the same latency; DEPTH=0 is a straight wire.
module vga_sync_delay
    import vga_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic      clk_i,
    input  logic      rst_i,
    input  vga_sync_t d_i,
    output vga_sync_t q_o
);

    if (DEPTH == 0) begin : g_pass
        assign q_o = d_i;
    end else begin : g_pipe
        vga_sync_t stage_q [DEPTH];

        // Reset clears every stage so no stale pulse escapes after a restart.
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                for (int i = 0; i < DEPTH; i++) begin
                    stage_q[i] <= '0;
                end
            end else begin
                stage_q[0] <= d_i;
                for (int i = 1; i < DEPTH; i++) begin
                    stage_q[i] <= stage_q[i-1];
                end
            end
        end

        assign q_o = stage_q[DEPTH-1];
    end

endmodule

// File: rtl/vga_timing_generator.sv
// VGA raster timing: pixel/line counters, active-area flag, frame counter and
// sync pulses delayed to match a PIPE_DELAY-clock colour pipeline.
module vga_timing_generator
    import vga_pkg::*;
#(
    parameter int H_ACTIVE        = VGA_H_ACTIVE,
    parameter int H_FRONT         = VGA_H_FRONT,
    parameter int H_SYNC          = VGA_H_SYNC,
    parameter int H_BACK          = VGA_H_BACK,
    parameter int V_ACTIVE        = VGA_V_ACTIVE,
    parameter int V_FRONT         = VGA_V_FRONT,
    parameter int V_SYNC          = VGA_V_SYNC,
    parameter int V_BACK          = VGA_V_BACK,
    parameter int SYNC_ACTIVE_LOW = 1,
    parameter int PIPE_DELAY      = 1
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    output logic [VGA_CNT_W-1:0] o_px,
    output logic [VGA_CNT_W-1:0] o_py,
    output logic                 o_activeArea,
    output logic                 o_activeAreaDly,
    output logic                 o_hsync,
    output logic                 o_vsync,
    output logic                 o_frameStart,
    output logic [15:0]          o_frame
);

    localparam int H_TOTAL  = vga_total(H_ACTIVE, H_FRONT, H_SYNC, H_BACK);
    localparam int V_TOTAL  = vga_total(V_ACTIVE, V_FRONT, V_SYNC, V_BACK);
    localparam int HS_START = H_ACTIVE + H_FRONT;
    localparam int VS_START = V_ACTIVE + V_FRONT;

    localparam logic [VGA_CNT_W-1:0] H_LAST = VGA_CNT_W'(H_TOTAL - 1);
    localparam logic [VGA_CNT_W-1:0] V_LAST = VGA_CNT_W'(V_TOTAL - 1);
    // One extra bit so bounds equal to 1024 do not alias to zero.
    localparam logic [VGA_CNT_W:0] H_ACT_L = (VGA_CNT_W+1)'(H_ACTIVE);
    localparam logic [VGA_CNT_W:0] V_ACT_L = (VGA_CNT_W+1)'(V_ACTIVE);
    localparam logic [VGA_CNT_W:0] HS_LO   = (VGA_CNT_W+1)'(HS_START);
    localparam logic [VGA_CNT_W:0] HS_HI   = (VGA_CNT_W+1)'(HS_START + H_SYNC);
    localparam logic [VGA_CNT_W:0] VS_LO   = (VGA_CNT_W+1)'(VS_START);
    localparam logic [VGA_CNT_W:0] VS_HI   = (VGA_CNT_W+1)'(VS_START + V_SYNC);
    localparam logic SYNC_POL = (SYNC_ACTIVE_LOW != 0);

    if (H_TOTAL > VGA_MAX_TOTAL) begin : g_h_total_too_big
        $error("vga_timing_generator: H_TOTAL exceeds 10-bit counter range");
    end
    if (V_TOTAL > VGA_MAX_TOTAL) begin : g_v_total_too_big
        $error("vga_timing_generator: V_TOTAL exceeds 10-bit counter range");
    end
    if (PIPE_DELAY > VGA_MAX_PIPE || PIPE_DELAY < 0) begin : g_pipe_out_of_range
        $error("vga_timing_generator: PIPE_DELAY must be 0..4");
    end

    logic [VGA_CNT_W-1:0] px_q, px_d;
    logic [VGA_CNT_W-1:0] py_q, py_d;
    logic                 active_q, active_d;
    logic                 frame_start_q, frame_start_d;
    logic [15:0]          frame_q, frame_d;
    vga_sync_t            raw;
    vga_sync_t            dly;

    // Flags are derived from the next counter values so they register in step.
    always_comb begin
        px_d = (px_q == H_LAST) ? '0 : px_q + 10'd1;
        py_d = py_q;
        if (px_q == H_LAST) begin
            py_d = (py_q == V_LAST) ? '0 : py_q + 10'd1;
        end
        active_d      = ({1'b0, px_d} < H_ACT_L) && ({1'b0, py_d} < V_ACT_L);
        frame_start_d = (px_d == '0) && (py_d == '0);
        frame_d       = frame_start_d ? frame_q + 16'd1 : frame_q;
    end

    // Reset parks the raster on the last pixel so the first edge lands on (0,0).
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            px_q          <= H_LAST;
            py_q          <= V_LAST;
            active_q      <= 1'b0;
            frame_start_q <= 1'b0;
            frame_q       <= 16'hFFFF;
        end else begin
            px_q          <= px_d;
            py_q          <= py_d;
            active_q      <= active_d;
            frame_start_q <= frame_start_d;
            frame_q       <= frame_d;
        end
    end

    always_comb begin
        raw        = '0;
        raw.active = active_q;
        raw.hsync  = ({1'b0, px_q} >= HS_LO) && ({1'b0, px_q} < HS_HI);
        raw.vsync  = ({1'b0, py_q} >= VS_LO) && ({1'b0, py_q} < VS_HI);
    end

    vga_sync_delay #(
        .DEPTH (PIPE_DELAY)
    ) u_sync_delay (
        .clk_i (i_clk),
        .rst_i (i_reset),
        .d_i   (raw),
        .q_o   (dly)
    );

    assign o_px            = px_q;
    assign o_py            = py_q;
    assign o_activeArea    = active_q;
    assign o_activeAreaDly = dly.active;
    assign o_hsync         = dly.hsync ^ SYNC_POL;
    assign o_vsync         = dly.vsync ^ SYNC_POL;
    assign o_frameStart    = frame_start_q;
    assign o_frame         = frame_q;

endmodule
